// File: rtl/rr_grant_pkg.sv
// Shared types, default parameters and the round-robin winner search
// for the clocked grant controller.
package rr_grant_pkg;

    localparam int N_REQ           = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_W      = 8;
    localparam int DEF_MAX_HOLD    = 200;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_REVOKE  = 2'd3
    } state_t;

    // Scans last+1, last+2, ... (mod n); the nearest set request wins.
    // Walking the offsets from far to near lets the closest hit overwrite.
    function automatic int rr_winner(input logic [31:0] req, input int last, input int n);
        int idx;
        int win;
        win = last;
        for (int i = 32; i >= 1; i--) begin
            if (i <= n) begin
                idx = last + i;
                if (idx >= n) begin
                    idx = idx - n;
                end else begin
                    idx = idx;
                end
                if (req[idx]) begin
                    win = idx;
                end else begin
                    win = win;
                end
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous pad input; clears to 0 on reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the pad level through the synchronizer chain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/rr_grant_ctrl.sv
// Clocked round-robin grant controller: synchronizes pad requests and runs a
// four-phase request/grant handshake with a bounded hold time.
module rr_grant_ctrl #(
    parameter int N_REQ       = rr_grant_pkg::N_REQ,
    parameter int SYNC_STAGES = rr_grant_pkg::DEF_SYNC_STAGES,
    parameter int HOLD_W      = rr_grant_pkg::DEF_HOLD_W,
    parameter int MAX_HOLD    = rr_grant_pkg::DEF_MAX_HOLD
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] gnt_oeb_o,
    output logic [1:0]       owner_o,
    output logic             busy_o,
    output logic             timeout_o
);

    import rr_grant_pkg::*;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [N_REQ-1:0]  w_req_s;
    logic [1:0]        w_win;
    logic [N_REQ-1:0]  w_win_oh;
    logic              w_any;
    logic              w_owner_req;

    state_t            r_state;
    logic [HOLD_W-1:0] r_cnt;
    logic [1:0]        r_last;
    logic [1:0]        r_owner;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  r_oeb;
    logic              r_busy;
    logic              r_timeout;

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_sync
            sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
                .i_clk (wb_clk_i),
                .i_rst (wb_rst_i),
                .i_d   (req_i[g]),
                .o_q   (w_req_s[g])
            );
        end
    endgenerate

    assign w_any       = |w_req_s;
    assign w_win       = 2'(rr_winner({{(32-N_REQ){1'b0}}, w_req_s}, int'(r_last), N_REQ));
    assign w_win_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
    assign w_owner_req = w_req_s[r_owner];

    // Pad drivers are enabled from the first clock edge after reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_oeb <= {N_REQ{1'b1}};
        end else begin
            r_oeb <= {N_REQ{1'b0}};
        end
    end

    // Handshake FSM; every output it drives is registered here.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_last    <= 2'(N_REQ - 1);
            r_owner   <= 2'd0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_win_oh;
                        r_busy  <= 1'b1;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_cnt   <= '0;
                        r_state <= ST_GRANT;
                    end else begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // A release seen on the final hold cycle beats the timeout.
                    if (!w_owner_req) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_RELEASE;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_REVOKE;
                    end else begin
                        r_cnt <= r_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RELEASE: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_REVOKE: begin
                    r_gnt  <= '0;
                    r_busy <= 1'b0;
                    if (!w_owner_req) begin
                        r_state <= ST_RELEASE;
                    end else begin
                        r_state <= ST_REVOKE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_oeb_o = r_oeb;
    assign owner_o   = r_owner;
    assign busy_o    = r_busy;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: a cycle-level reference model predicts
// every grant (owner, start, length, timeout) and a monitor checks the DUT.
module tb_rr_grant_ctrl;

    localparam int N    = 3;
    localparam int SS   = 2;
    localparam int HW   = 8;
    localparam int MAXH = 10;

    typedef struct {
        int owner;
        int start;
        int len;
        bit to;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] gnt_o;
    logic [N-1:0] gnt_oeb_o;
    logic [1:0]   owner_o;
    logic         busy_o;
    logic         timeout_o;

    rr_grant_ctrl #(.N_REQ(N), .SYNC_STAGES(SS), .HOLD_W(HW), .MAX_HOLD(MAXH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .gnt_oeb_o (gnt_oeb_o),
        .owner_o   (owner_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    rec_t exp_q[$];
    int   model_to = 0;
    int   obs_to   = 0;
    int   last_len = -1;
    int   last_to  = -1;
    bit   mon_act  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the FSM sees req_i as sampled SS edges earlier.
    initial begin
        logic [N-1:0] hist[$];
        logic [N-1:0] r;
        int m_owner = -1;
        int m_last = N - 1;
        int m_start = 0;
        int m_allowed = 0;
        bit m_wait = 1'b0;
        int idx;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                hist.delete();
                m_owner = -1; m_last = N - 1; m_wait = 1'b0; m_allowed = 0;
            end else begin
                r = (hist.size() >= SS) ? hist[hist.size() - SS] : '0;
                hist.push_back(req_i);
                if (hist.size() > 8) void'(hist.pop_front());
                if (m_owner >= 0) begin
                    if (!r[m_owner]) begin
                        exp_q.push_back('{m_owner, m_start, cyc - m_start, 1'b0});
                        m_owner = -1; m_allowed = cyc + 2;
                    end else if (cyc - m_start == MAXH) begin
                        exp_q.push_back('{m_owner, m_start, MAXH, 1'b1});
                        m_owner = -1; m_wait = 1'b1; model_to++;
                    end
                end else if (m_wait) begin
                    if (!r[m_last]) begin
                        m_wait = 1'b0; m_allowed = cyc + 2;
                    end
                end else if (cyc >= m_allowed && r != '0) begin
                    for (int off = N; off >= 1; off--) begin
                        idx = (m_last + off) % N;
                        if (r[idx]) m_owner = idx;
                    end
                    m_last = m_owner; m_start = cyc;
                end
            end
        end
    end

    // Monitor: per-cycle invariants plus a scoreboard pop at each grant end.
    initial begin
        int a_owner = 0;
        int a_start = 0;
        rec_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_act = 1'b0;
                chk("rst_gnt", int'(gnt_o), 0);
                chk("rst_oeb", int'(gnt_oeb_o), (1 << N) - 1);
                chk("rst_busy", int'(busy_o), 0);
                chk("rst_timeout", int'(timeout_o), 0);
                chk("rst_owner", int'(owner_o), 0);
            end else begin
                chk("oeb", int'(gnt_oeb_o), 0);
                chk("busy", int'(busy_o), (gnt_o != '0) ? 1 : 0);
                chk("onehot", ($countones(gnt_o) <= 1) ? 1 : 0, 1);
                if (!mon_act && gnt_o != '0) begin
                    mon_act = 1'b1; a_start = cyc;
                    for (int i = 0; i < N; i++) if (gnt_o[i]) a_owner = i;
                    chk("owner_o", int'(owner_o), a_owner);
                    chk("spurious_timeout", int'(timeout_o), 0);
                end else if (mon_act && gnt_o != '0) begin
                    chk("grant_stable", int'(gnt_o), 1 << a_owner);
                    chk("owner_o", int'(owner_o), a_owner);
                    chk("spurious_timeout", int'(timeout_o), 0);
                end else if (mon_act) begin
                    mon_act = 1'b0;
                    if (timeout_o) obs_to++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", a_owner, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_owner", a_owner, e.owner);
                        chk("grant_start", a_start, e.start);
                        chk("grant_len", cyc - a_start, e.len);
                        chk("grant_timeout", int'(timeout_o), int'(e.to));
                    end
                    last_len = cyc - a_start;
                    last_to  = int'(timeout_o);
                end else begin
                    chk("spurious_timeout", int'(timeout_o), 0);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    int  held[N];
    int  hold_len[N];
    bit  seen[N];

    // Requester agents: mode 0 = steady contention, mode 1 = random traffic.
    task automatic agent_tick(input int mode);
        for (int i = 0; i < N; i++) begin
            if (!req_i[i]) begin
                if (!gnt_o[i] && (mode == 0 || $urandom_range(3) == 0)) begin
                    req_i[i] = 1'b1; seen[i] = 1'b0; held[i] = 0;
                    hold_len[i] = (mode == 0) ? 4 : $urandom_range(14, 1);
                end
            end else begin
                if (gnt_o[i]) seen[i] = 1'b1;
                if (seen[i]) begin
                    if (gnt_o[i]) held[i]++;
                    if (held[i] >= hold_len[i] || !gnt_o[i]) req_i[i] = 1'b0;
                end else if (mode == 1 && $urandom_range(39) == 0) begin
                    req_i[i] = 1'b0;
                end
            end
        end
        tick();
    endtask

    initial begin
        int g;
        int to0;
        bit found;
        repeat (5) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Single request, then release.
        req_i = 3'b001;
        repeat (8) tick();
        req_i = 3'b000;
        repeat (6) tick();

        // Full contention.
        for (int c = 0; c < 45; c++) agent_tick(0);
        req_i = 3'b000;
        repeat (8) tick();

        // Timeout with a pending second requester.
        to0 = obs_to;
        req_i = 3'b010;
        repeat (5) tick();
        req_i = 3'b011;
        repeat (20) tick();
        req_i = 3'b001;
        repeat (8) tick();
        req_i = 3'b000;
        repeat (8) tick();
        chk("timeout_count", obs_to - to0, 1);

        // Release landing on the last hold cycle: no timeout.
        to0 = obs_to;
        req_i = 3'b001;
        found = 1'b0;
        g = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (gnt_o[0]) begin found = 1'b1; g = cyc; end
        end
        chk("collision_grant_seen", int'(found), 1);
        while (found && cyc < g + MAXH - 3) tick();
        req_i = 3'b000;
        repeat (8) tick();
        chk("collision_len", last_len, MAXH);
        chk("collision_timeout", last_to, 0);
        chk("collision_timeout_count", obs_to - to0, 0);

        // Reset in the middle of a grant to requester 2.
        req_i = 3'b100;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (gnt_o == 3'b100) found = 1'b1;
        end
        chk("midrst_grant_seen", int'(found), 1);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_gnt_clear", int'(gnt_o), 0);
        chk("midrst_timeout", int'(timeout_o), 0);
        req_i = 3'b101;
        repeat (3) tick();
        rst = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (gnt_o != '0) found = 1'b1;
        end
        chk("midrst_first_winner", int'(gnt_o), 1);
        req_i = 3'b000;
        repeat (8) tick();

        // Randomized traffic, long holds trigger timeouts.
        for (int i = 0; i < N; i++) begin held[i] = 0; hold_len[i] = 1; seen[i] = 1'b0; end
        for (int c = 0; c < 1500; c++) agent_tick(1);
        req_i = 3'b000;
        repeat (20) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("grant_idle_at_end", int'(mon_act), 0);
        chk("total_timeouts", obs_to, model_to);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
